// File: rtl/ro_freq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : ro_freq_monitor
// Brief    : Counts synchronised ring-oscillator rising edges per gate window
//            and raises a debounced fail when the count is below fro_min.
// Revision : 1.0 - initial release
// ============================================================================
module ro_freq_monitor #(
    parameter int WIDTH       = 8,
    parameter int GATE_CYCLES = 256,
    parameter int FAIL_COUNT  = 2,
    parameter int PASS_COUNT  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             main_clock,
    input  logic             main_reset,
    input  logic             ro_external,
    input  logic             enable,
    input  logic [WIDTH-1:0] fro_min,
    output logic [WIDTH-1:0] count,
    output logic             count_valid,
    output logic             fail
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam int FW = $clog2(FAIL_COUNT + 1);
    localparam int PW = $clog2(PASS_COUNT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_EVAL    = 2'd2;

    localparam logic [GW-1:0]    C_GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [WIDTH-1:0] C_CNT_MAX   = '1;
    localparam logic [FW-1:0]    C_FAIL_LAST = FW'(FAIL_COUNT - 1);
    localparam logic [PW-1:0]    C_PASS_LAST = PW'(PASS_COUNT - 1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic [GW-1:0]          r_gate_cnt;
    logic [WIDTH-1:0]       r_edge_cnt;
    logic [FW-1:0]          r_low_streak;
    logic [PW-1:0]          r_ok_streak;
    logic                   w_edge;
    logic                   w_measure;
    logic                   w_win_end;
    logic                   w_abort;
    logic [WIDTH-1:0]       w_edge_final;
    logic                   w_low;

    // r_sync_prev holds the last stage one cycle back so w_edge is a clean rising-edge pulse
    always_ff @(posedge main_clock or posedge main_reset) begin
        if (main_reset) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], ro_external};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_sync_prev;

    always_ff @(posedge main_clock or posedge main_reset) begin
        if (main_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) w_state_next = S_MEASURE;
            end
            S_MEASURE: begin
                if (r_gate_cnt == C_GATE_LAST) w_state_next = S_EVAL;
                else if (!enable)              w_state_next = S_IDLE;
            end
            S_EVAL: begin
                w_state_next = enable ? S_MEASURE : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // A window in its final gate cycle completes even if enable has dropped
    always_comb begin
        w_measure = 1'b0;
        w_win_end = 1'b0;
        w_abort   = 1'b0;
        if (r_state == S_MEASURE) begin
            w_measure = 1'b1;
            w_win_end = (r_gate_cnt == C_GATE_LAST);
            w_abort   = (r_gate_cnt != C_GATE_LAST) && !enable;
        end
    end

    assign w_edge_final = (r_edge_cnt == C_CNT_MAX) ? C_CNT_MAX : r_edge_cnt + WIDTH'(w_edge);
    assign w_low        = (w_edge_final < fro_min);

    always_ff @(posedge main_clock or posedge main_reset) begin
        if (main_reset) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
        end else if (w_measure) begin
            r_gate_cnt <= r_gate_cnt + 1'b1;
            r_edge_cnt <= w_edge_final;
        end else begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
        end
    end

    always_ff @(posedge main_clock or posedge main_reset) begin
        if (main_reset) begin
            count       <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= w_win_end;
            if (w_win_end) count <= w_edge_final;
        end
    end

    // Streaks only ever reach the threshold minus one: hitting it flips fail and clears both
    always_ff @(posedge main_clock or posedge main_reset) begin
        if (main_reset) begin
            fail         <= 1'b0;
            r_low_streak <= '0;
            r_ok_streak  <= '0;
        end else if (w_win_end) begin
            if (!fail) begin
                if (w_low) begin
                    if (r_low_streak == C_FAIL_LAST) begin
                        fail         <= 1'b1;
                        r_low_streak <= '0;
                        r_ok_streak  <= '0;
                    end else begin
                        r_low_streak <= r_low_streak + 1'b1;
                    end
                end else begin
                    r_low_streak <= '0;
                end
            end else begin
                if (!w_low) begin
                    if (r_ok_streak == C_PASS_LAST) begin
                        fail         <= 1'b0;
                        r_low_streak <= '0;
                        r_ok_streak  <= '0;
                    end else begin
                        r_ok_streak <= r_ok_streak + 1'b1;
                    end
                end else begin
                    r_ok_streak <= '0;
                end
            end
        end else if (w_abort) begin
            r_low_streak <= '0;
            r_ok_streak  <= '0;
        end
    end

endmodule
`default_nettype wire
